// File: rtl/wb_commit_if.sv
// Register-file writeback bundle: pipeline WB request, LU result handshake,
// the registered write port and the hazard-side status outputs.
interface wb_commit_if #(
    parameter int DATA_W = 32
);
    logic              pipe_we;
    logic [4:0]        pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_load;
    logic [2:0]        pipe_funct3;
    logic [1:0]        pipe_addr_lo;
    logic              lu_valid;
    logic [4:0]        lu_rd;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    logic [4:0]        Address3;
    logic              RegWriteEN3;
    logic [DATA_W-1:0] RegDataW3;
    logic [31:0]       pending_mask;
    logic              pipe_stall;

    modport master (
        output pipe_we, pipe_rd, pipe_data, pipe_load, pipe_funct3, pipe_addr_lo,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready, Address3, RegWriteEN3, RegDataW3, pending_mask, pipe_stall
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, pipe_load, pipe_funct3, pipe_addr_lo,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready, Address3, RegWriteEN3, RegDataW3, pending_mask, pipe_stall
    );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Writeback commit arbiter: merges in-order pipeline results and buffered
// long-latency unit results onto a single registered register-file write port.
module wb_commit_arbiter #(
    parameter int DATA_W     = 32,
    parameter int LU_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input logic        clk,
    input logic        rst,
    wb_commit_if.slave bus
);
    localparam int PTR_W = $clog2(LU_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic              is_load,
        input logic [2:0]        funct3,
        input logic [1:0]        addr_lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        load_extend = word;
        if (is_load) begin
            case (funct3)
                3'b000:  load_extend = {{(DATA_W-8){b[7]}}, b};
                3'b001:  load_extend = {{(DATA_W-16){h[15]}}, h};
                3'b100:  load_extend = {{(DATA_W-8){1'b0}}, b};
                3'b101:  load_extend = {{(DATA_W-16){1'b0}}, h};
                default: load_extend = word;
            endcase
        end
    endfunction

    logic [4:0]        fifo_rd_q   [LU_DEPTH];
    logic [4:0]        fifo_rd_d   [LU_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [LU_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [LU_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              wen_q, wen_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              lu_ready, push, pipe_sel, pop;
    logic [31:0]       pending_mask;

    // Handshake, selection and FIFO bookkeeping
    always_comb begin
        lu_ready  = (count_q != CNT_W'(LU_DEPTH));
        push      = bus.lu_valid && lu_ready && (bus.lu_rd != 5'd0);
        pipe_sel  = bus.pipe_we && (bus.pipe_rd != 5'd0);
        pop       = !pipe_sel && (count_q != '0);

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = bus.lu_rd;
            fifo_data_d[wr_ptr_q] = bus.lu_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_sel) begin
            wen_d   = 1'b1;
            waddr_d = bus.pipe_rd;
            wdata_d = load_extend(bus.pipe_data, bus.pipe_load, bus.pipe_funct3, bus.pipe_addr_lo);
        end else if (pop) begin
            wen_d   = 1'b1;
            waddr_d = fifo_rd_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Denial counter only grows while an entry waits and the pipeline keeps winning
    always_comb begin
        if (pop || (count_q == '0)) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end else begin
            starve_d = starve_q;
        end
        stall_d = (starve_d == STV_W'(STARVE_MAX));
    end

    always_comb begin
        pending_mask = '0;
        idx          = rd_ptr_q;
        for (int i = 0; i < LU_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                pending_mask[fifo_rd_q[idx]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Entry storage is qualified by count_q, so it needs no reset
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign bus.lu_ready     = lu_ready;
    assign bus.Address3     = waddr_q;
    assign bus.RegWriteEN3  = wen_q;
    assign bus.RegDataW3    = wdata_q;
    assign bus.pending_mask = pending_mask;
    assign bus.pipe_stall   = stall_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_wb_commit_arbiter;
    localparam int DATA_W     = 32;
    localparam int LU_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ent_t        mq[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_denied;

    always #5 clk = ~clk;

    wb_commit_if #(.DATA_W(DATA_W)) bus ();

    wb_commit_arbiter #(
        .DATA_W(DATA_W), .LU_DEPTH(LU_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic ld,
                                            input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] v;
        v = w;
        if (ld) begin
            case (f3)
                3'd0: begin v = (w >> (8 * a)) & 32'hFF;  if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
                3'd1: begin v = (w >> (16 * a[1])) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
                3'd4: v = (w >> (8 * a)) & 32'hFF;
                3'd5: v = (w >> (16 * a[1])) & 32'hFFFF;
                default: v = w;
            endcase
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
        return m;
    endfunction

    // Reference model advanced with the inputs as they stand at the coming edge
    task automatic model_edge();
        ent_t e;
        bit   acc;
        if (rst) begin
            mq.delete();
            m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_denied = 0;
        end else begin
            acc = bus.lu_valid && (mq.size() < LU_DEPTH);
            if (bus.pipe_we && bus.pipe_rd != 5'd0) begin
                m_en   = 1'b1;
                m_addr = bus.pipe_rd;
                m_data = ref_ext(bus.pipe_data, bus.pipe_load, bus.pipe_funct3, bus.pipe_addr_lo);
                if (mq.size() > 0) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
                else m_denied = 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_en = 1'b1; m_addr = e.rd; m_data = e.data; m_denied = 0;
            end else begin
                m_en = 1'b0; m_denied = 0;
            end
            if (acc && bus.lu_rd != 5'd0) begin
                e.rd = bus.lu_rd; e.data = bus.lu_data;
                mq.push_back(e);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.pipe_we = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = 32'd0; bus.pipe_load = 1'b0;
        bus.pipe_funct3 = 3'd0; bus.pipe_addr_lo = 2'd0;
        bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_data = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d, input logic ld,
                              input logic [2:0] f3, input logic [1:0] a);
        bus.pipe_we = 1'b1; bus.pipe_rd = rd; bus.pipe_data = d; bus.pipe_load = ld;
        bus.pipe_funct3 = f3; bus.pipe_addr_lo = a;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_rd = rd; bus.lu_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_pipe(5'd7, 32'hDEAD_BEEF, 1'b0, 3'd2, 2'd0);
        drive_lu(1'b1, 5'd3, 32'h1234);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (bus.RegWriteEN3 !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", bus.RegWriteEN3); end
            checks++; if (bus.Address3 !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus.Address3); end
            checks++; if (bus.RegDataW3 !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.RegDataW3); end
            checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.pipe_stall); end
            checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask got %h want 0", bus.pending_mask); end
        end
        rst = 1'b0;
        idle_inputs();
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.lu_ready); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b0) begin errors++; $display("FAIL reset_release_en got %0b want 0", bus.RegWriteEN3); end
        checks++; if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL reset_release_mask got %h want 0", bus.pending_mask); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3   [7] = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd5, 3'd1, 3'd0};
        logic [1:0]  al   [7] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [31:0] din  [7] = '{32'h12803456, 32'h12803456, 32'h12803456, 32'h12803456,
                                  32'h12803456, 32'h00008001, 32'h000000F0};
        logic        ld   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] want [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'h12803456,
                                  32'h00003456, 32'hFFFF8001, 32'h000000F0};
        for (int k = 0; k < 7; k++) begin
            drive_pipe(5'd7, din[k], ld[k], f3[k], al[k]);
            step();
            checks++; if (bus.RegDataW3 !== want[k]) begin errors++; $display("FAIL load_ext[%0d] got %h want %h", k, bus.RegDataW3, want[k]); end
            checks++; if (bus.Address3 !== 5'd7 || bus.RegWriteEN3 !== 1'b1) begin errors++; $display("FAIL load_ext_port[%0d] got addr=%0d en=%0b want addr=7 en=1", k, bus.Address3, bus.RegWriteEN3); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_arbitration();
        drive_pipe(5'd6, 32'h11, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd5, 32'hA5A5);
        step();
        idle_inputs();
        checks++; if (bus.RegWriteEN3 !== 1'b1 || bus.Address3 !== 5'd6 || bus.RegDataW3 !== 32'h11) begin errors++; $display("FAIL arb_pipe got en=%0b x%0d=%h want en=1 x6=11", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        checks++; if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL arb_mask_set got %h want 20", bus.pending_mask); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b1 || bus.Address3 !== 5'd5 || bus.RegDataW3 !== 32'hA5A5) begin errors++; $display("FAIL arb_lu got en=%0b x%0d=%h want en=1 x5=a5a5", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL arb_mask_clr got %h want 0", bus.pending_mask); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b0 || bus.Address3 !== 5'd5 || bus.RegDataW3 !== 32'hA5A5) begin errors++; $display("FAIL arb_hold got en=%0b x%0d=%h want en=0 x5=a5a5", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
    endtask

    task automatic test_fifo_full();
        drive_pipe(5'd10, 32'h1010, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd3, 32'h333);
        step();
        drive_lu(1'b1, 5'd4, 32'h444);
        step();
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", bus.lu_ready); end
        drive_lu(1'b1, 5'd9, 32'h999);
        step();
        checks++; if (bus.lu_ready !== 1'b0 || bus.pending_mask !== 32'h18) begin errors++; $display("FAIL full_stalled got ready=%0b mask=%h want ready=0 mask=18", bus.lu_ready, bus.pending_mask); end
        bus.pipe_we = 1'b0;
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b1 || bus.Address3 !== 5'd3 || bus.RegDataW3 !== 32'h333) begin errors++; $display("FAIL full_pop0 got en=%0b x%0d=%h want x3=333", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %0b want 1", bus.lu_ready); end
        step();
        drive_lu(1'b0, 5'd0, 32'd0);
        checks++; if (bus.RegWriteEN3 !== 1'b1 || bus.Address3 !== 5'd4 || bus.RegDataW3 !== 32'h444) begin errors++; $display("FAIL full_pop1 got en=%0b x%0d=%h want x4=444", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b1 || bus.Address3 !== 5'd9 || bus.RegDataW3 !== 32'h999) begin errors++; $display("FAIL full_pop2 got en=%0b x%0d=%h want x9=999", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b0 || bus.pending_mask !== 32'h0) begin errors++; $display("FAIL full_drained got en=%0b mask=%h want en=0 mask=0", bus.RegWriteEN3, bus.pending_mask); end
    endtask

    task automatic test_starvation();
        drive_pipe(5'd11, 32'hB0, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd8, 32'h888);
        step();
        drive_lu(1'b0, 5'd0, 32'd0);
        for (int d = 1; d <= STARVE_MAX + 1; d++) begin
            step();
            checks++; if (bus.pipe_stall !== (d >= STARVE_MAX)) begin errors++; $display("FAIL starve_stall[%0d] got %0b want %0b", d, bus.pipe_stall, (d >= STARVE_MAX)); end
        end
        checks++; if (bus.Address3 !== 5'd11 || bus.RegWriteEN3 !== 1'b1) begin errors++; $display("FAIL starve_pipe_wins got en=%0b x%0d want x11", bus.RegWriteEN3, bus.Address3); end
        bus.pipe_we = 1'b0;
        step();
        checks++; if (bus.Address3 !== 5'd8 || bus.RegDataW3 !== 32'h888 || bus.RegWriteEN3 !== 1'b1) begin errors++; $display("FAIL starve_pop got en=%0b x%0d=%h want x8=888", bus.RegWriteEN3, bus.Address3, bus.RegDataW3); end
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_release got %0b want 0", bus.pipe_stall); end
        // counter restarted from zero: a fresh wait of MAX-1 cycles must not stall
        drive_pipe(5'd11, 32'hB1, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd12, 32'hC12);
        step();
        drive_lu(1'b0, 5'd0, 32'd0);
        for (int d = 1; d < STARVE_MAX; d++) step();
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_restart got %0b want 0", bus.pipe_stall); end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_x0_filter();
        drive_pipe(5'd0, 32'h5555, 1'b0, 3'd0, 2'd0);
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b0) begin errors++; $display("FAIL x0_pipe got en=%0b want 0", bus.RegWriteEN3); end
        drive_pipe(5'd14, 32'hE, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd13, 32'hD13);
        step();
        drive_pipe(5'd15, 32'hF, 1'b0, 3'd0, 2'd0);
        drive_lu(1'b1, 5'd0, 32'h0BAD);
        step();
        checks++; if (bus.pending_mask !== 32'h2000 || bus.lu_ready !== 1'b1) begin errors++; $display("FAIL x0_lu got mask=%h ready=%0b want mask=2000 ready=1", bus.pending_mask, bus.lu_ready); end
        idle_inputs();
        step();
        checks++; if (bus.Address3 !== 5'd13 || bus.RegDataW3 !== 32'hD13) begin errors++; $display("FAIL x0_pop got x%0d=%h want x13=d13", bus.Address3, bus.RegDataW3); end
        step();
        checks++; if (bus.RegWriteEN3 !== 1'b0 || bus.pending_mask !== 32'h0) begin errors++; $display("FAIL x0_nowrite got en=%0b mask=%h want en=0 mask=0", bus.RegWriteEN3, bus.pending_mask); end
    endtask

    task automatic test_random();
        int busy;
        busy = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) busy = ($urandom_range(0, 1) == 1) ? 90 : 25;
            rst = ($urandom_range(0, 149) == 0);
            bus.pipe_we      = ($urandom_range(0, 99) < busy);
            bus.pipe_rd      = 5'($urandom_range(0, 15));
            bus.pipe_data    = $urandom;
            bus.pipe_load    = 1'($urandom_range(0, 1));
            bus.pipe_funct3  = 3'($urandom_range(0, 7));
            bus.pipe_addr_lo = 2'($urandom_range(0, 3));
            bus.lu_valid     = 1'($urandom_range(0, 1));
            bus.lu_rd        = 5'($urandom_range(0, 15));
            bus.lu_data      = $urandom;
            step();
            checks++; if (bus.RegWriteEN3 !== m_en) begin errors++; $display("FAIL rnd_en c=%0d got %0b want %0b", c, bus.RegWriteEN3, m_en); end
            checks++; if (bus.Address3 !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d got %0d want %0d", c, bus.Address3, m_addr); end
            checks++; if (bus.RegDataW3 !== m_data) begin errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, bus.RegDataW3, m_data); end
            checks++; if (bus.pending_mask !== exp_mask()) begin errors++; $display("FAIL rnd_mask c=%0d got %h want %h", c, bus.pending_mask, exp_mask()); end
            checks++; if (bus.lu_ready !== (mq.size() < LU_DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, bus.lu_ready, (mq.size() < LU_DEPTH)); end
            checks++; if (bus.pipe_stall !== (m_denied == STARVE_MAX)) begin errors++; $display("FAIL rnd_stall c=%0d got %0b want %0b", c, bus.pipe_stall, (m_denied == STARVE_MAX)); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_denied = 0;
        @(negedge clk);
        test_reset();
        test_load_ext();
        test_arbitration();
        test_fifo_full();
        test_starvation();
        test_x0_filter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
